// File: rtl/axi4_lite_slave_ram_pkg.sv
// Shared types for the AXI4-lite RAM responder: FSM state encodings and
// the clogb2 helper used to size the word index.
package axi4_lite_slave_ram_pkg;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_VALID}                    r_state_t;

   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axi4_lite_slave_ram_if.sv
// AXI4-lite channel subset used by axi4_interconnect: no BRESP/RRESP.
interface axi4_lite_slave_ram_if #(parameter int sword = 32);

   logic             s_axi_awvalid;
   logic             s_axi_awready;
   logic [sword-1:0] s_axi_awaddr;
   logic [2:0]       s_axi_awprot;
   logic             s_axi_wvalid;
   logic             s_axi_wready;
   logic [sword-1:0] s_axi_wdata;
   logic [3:0]       s_axi_wstrb;
   logic             s_axi_bvalid;
   logic             s_axi_bready;
   logic             s_axi_arvalid;
   logic             s_axi_arready;
   logic [sword-1:0] s_axi_araddr;
   logic [2:0]       s_axi_arprot;
   logic             s_axi_rvalid;
   logic             s_axi_rready;
   logic [sword-1:0] s_axi_rdata;

   modport slave (
      input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
      input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
      input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid,
      output s_axi_arready, s_axi_rvalid, s_axi_rdata
   );

   modport master (
      output s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
      output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
      output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid,
      input  s_axi_arready, s_axi_rvalid, s_axi_rdata
   );

endinterface

// File: rtl/axi4_lite_slave_ram_core.sv
// depth x sword RAM: one byte-enabled write port, one synchronous read port,
// read-first when both ports hit the same word on the same edge.
module axi4_lite_ram_core
   import axi4_lite_slave_ram_pkg::*;
#(
   parameter int sword = 32,
   parameter int depth = 256,
   localparam int aw   = clogb2(depth)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               we,
   input  logic [sword/8-1:0] wbe,
   input  logic [aw-1:0]      waddr,
   input  logic [sword-1:0]   wdata,
   input  logic               re,
   input  logic [aw-1:0]      raddr,
   output logic [sword-1:0]   rdata
);

   logic [sword-1:0] mem [depth];

   // NOTE: the array has no reset branch; contents survive RST and this maps
   // onto plain RAM macros instead of a bank of resettable flops.
   always_ff @(posedge CLK) begin
      if (we) begin
         for (int b = 0; b < sword/8; b++) begin
            if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // NOTE: non-blocking writes above are what make a same-edge read see the old word.
   always_ff @(posedge CLK) begin
      if (RST)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi4_lite_slave_ram.sv
// AXI4-lite responder backed by a word-addressed RAM with byte strobes.
// Independent write and read FSMs; all outputs come from flops.
module axi4_lite_slave_ram
   import axi4_lite_slave_ram_pkg::*;
#(
   parameter int sword = 32,
   parameter int depth = 256
) (
   input logic                  CLK,
   input logic                  RST,
   axi4_lite_slave_ram_if.slave s_axi
);

   localparam int aw = clogb2(depth);

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic             aw_hs, w_hs, ar_hs;
   logic [aw-1:0]    addr_q;
   logic [sword-1:0] data_q;
   logic [3:0]       strb_q;
   logic             ram_we, ram_re;
   logic [aw-1:0]    ram_waddr;
   logic [sword-1:0] ram_wdata;
   logic [3:0]       ram_wbe;
   logic             unused;

   assign aw_hs = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
   assign w_hs  = s_axi.s_axi_wvalid  & s_axi.s_axi_wready;
   assign ar_hs = s_axi.s_axi_arvalid & s_axi.s_axi_arready;

   // NOTE: next-state defaults to the current state first, so no path infers a latch.
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) w_next = W_RESP;
            else if (aw_hs)    w_next = W_HAVE_A;
            else if (w_hs)     w_next = W_HAVE_D;
         end
         W_HAVE_A: if (w_hs)                 w_next = W_RESP;
         W_HAVE_D: if (aw_hs)                w_next = W_RESP;
         W_RESP:   if (s_axi.s_axi_bready)   w_next = W_IDLE;
         default:                            w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)              r_next = R_VALID;
         R_VALID: if (s_axi.s_axi_rready) r_next = R_IDLE;
         default:                         r_next = R_IDLE;
      endcase
   end

   // Readys/valids are decoded from the next state so they are flops, yet 0 in reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         w_state             <= W_IDLE;
         r_state             <= R_IDLE;
         s_axi.s_axi_awready <= 1'b0;
         s_axi.s_axi_wready  <= 1'b0;
         s_axi.s_axi_bvalid  <= 1'b0;
         s_axi.s_axi_arready <= 1'b0;
         s_axi.s_axi_rvalid  <= 1'b0;
      end else begin
         w_state             <= w_next;
         r_state             <= r_next;
         s_axi.s_axi_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
         s_axi.s_axi_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
         s_axi.s_axi_bvalid  <= (w_next == W_RESP);
         s_axi.s_axi_arready <= (r_next == R_IDLE);
         s_axi.s_axi_rvalid  <= (r_next == R_VALID);
      end
   end

   always_ff @(posedge CLK) begin
      if (aw_hs) addr_q <= s_axi.s_axi_awaddr[aw+1:2];
      if (w_hs) begin
         data_q <= s_axi.s_axi_wdata;
         strb_q <= s_axi.s_axi_wstrb;
      end
   end

   // Commit on the edge entering W_RESP; whichever half arrives now bypasses its latch.
   assign ram_we    = !RST && (w_state != W_RESP) && (w_next == W_RESP);
   assign ram_waddr = aw_hs ? s_axi.s_axi_awaddr[aw+1:2] : addr_q;
   assign ram_wdata = w_hs  ? s_axi.s_axi_wdata          : data_q;
   assign ram_wbe   = w_hs  ? s_axi.s_axi_wstrb          : strb_q;
   assign ram_re    = !RST && ar_hs;

   axi4_lite_ram_core #(.sword(sword), .depth(depth)) u_ram (
      .CLK   (CLK),
      .RST   (RST),
      .we    (ram_we),
      .wbe   (ram_wbe),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (s_axi.s_axi_araddr[aw+1:2]),
      .rdata (s_axi.s_axi_rdata)
   );

   assign unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                     s_axi.s_axi_awaddr[sword-1:aw+2], s_axi.s_axi_awaddr[1:0],
                     s_axi.s_axi_araddr[sword-1:aw+2], s_axi.s_axi_araddr[1:0]};

endmodule
